// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// FSM states and the default iteration count.
package mdu_pkg;

    localparam int ITER_CNT = 32;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic logic op_is_div(input op_t op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input op_t op);
        return op[0];
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: one shift-add or restoring
// shift-subtract step per cycle on a shared 2*WIDTH accumulator.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = ITER_CNT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             mt_hi,
    input  logic             mt_lo,
    input  logic [WIDTH-1:0] mt_data,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    state_t             state;
    op_t                op_q;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd_q;
    logic [WIDTH-1:0]   raw_a_q;
    logic               neg_lo_q;
    logic               neg_hi_q;
    logic               zero_div_q;

    // Operand conditioning at launch
    op_t              op_in;
    logic             in_signed;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    assign op_in     = op_t'(op);
    assign in_signed = op_is_signed(op_in);
    assign abs_a     = (in_signed && operand_a[WIDTH-1]) ? ('0 - operand_a) : operand_a;
    assign abs_b     = (in_signed && operand_b[WIDTH-1]) ? ('0 - operand_b) : operand_b;

    // Multiply keeps the multiplier in acc low half and shifts the
    // running product in from the top; divide shifts the dividend out
    // of the low half into the partial remainder.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH:0]   shifted;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] div_next;

    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc[WIDTH-1:1]};
        shifted  = {acc, 1'b0};
        trial    = shifted[2*WIDTH:WIDTH] - {1'b0, opnd_q};
        div_next = trial[WIDTH] ? shifted[2*WIDTH-1:0]
                                : {trial[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1};
    end

    // Sign correction applied in FIX
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        prod_fix = neg_lo_q ? ('0 - acc) : acc;
        quot_fix = neg_lo_q ? ('0 - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
        rem_fix  = neg_hi_q ? ('0 - acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            op_q        <= OP_MULTU;
            cnt         <= '0;
            acc         <= '0;
            opnd_q      <= '0;
            raw_a_q     <= '0;
            neg_lo_q    <= 1'b0;
            neg_hi_q    <= 1'b0;
            zero_div_q  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_q        <= op_in;
                        acc         <= {{WIDTH{1'b0}}, abs_a};
                        opnd_q      <= abs_b;
                        raw_a_q     <= operand_a;
                        neg_lo_q    <= in_signed & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
                        neg_hi_q    <= in_signed & operand_a[WIDTH-1];
                        zero_div_q  <= op_is_div(op_in) && (operand_b == '0);
                        cnt         <= '0;
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                        state       <= CALC;
                    end else begin
                        if (mt_hi) hi <= mt_data;
                        if (mt_lo) lo <= mt_data;
                    end
                end
                CALC: begin
                    acc <= op_is_div(op_q) ? div_next : mul_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(ITER - 1)) state <= FIX;
                end
                FIX: begin
                    if (!op_is_div(op_q)) begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end else if (zero_div_q) begin
                        hi <= raw_a_q;
                        lo <= '1;
                    end else begin
                        hi <= rem_fix;
                        lo <= quot_fix;
                    end
                    div_by_zero <= zero_div_q;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed cases plus random ops
// checked against plain-arithmetic reference results.
module tb_mult_div_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        mt_hi;
    logic        mt_lo;
    logic [31:0] mt_data;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b),
        .mt_hi(mt_hi), .mt_lo(mt_lo), .mt_data(mt_data),
        .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    logic [64:0] sb_q[$];
    logic [31:0] cur_hi = '0;
    logic [31:0] cur_lo = '0;
    int busy_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: {div_by_zero, hi, lo} from plain arithmetic
    function automatic logic [64:0] ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, sp, sq, sr;
        logic [63:0] up;
        sa = $signed(a);
        sb = $signed(b);
        case (o)
            2'b00: begin
                up = {32'b0, a} * {32'b0, b};
                return {1'b0, up};
            end
            2'b01: begin
                sp = sa * sb;
                return {1'b0, sp[63:0]};
            end
            2'b10: begin
                if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
                return {1'b0, a % b, a / b};
            end
            default: begin
                if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
                sq = sa / sb;
                sr = sa % sb;
                return {1'b0, sr[31:0], sq[31:0]};
            end
        endcase
    endfunction

    // Monitor: checks in-flight invariants and pops the scoreboard on done
    always @(negedge clock) begin
        logic [64:0] e;
        if (reset) begin
            busy_cnt = 0;
        end else begin
            if (busy) begin
                busy_cnt++;
                check("hi_stable_busy", {32'b0, hi}, {32'b0, cur_hi});
                check("lo_stable_busy", {32'b0, lo}, {32'b0, cur_lo});
                check("dbz_clear_busy", {63'b0, div_by_zero}, 64'd0);
            end
            if (done) begin
                check("busy_cycles", 64'(busy_cnt), 64'd33);
                check("busy_low_done", {63'b0, busy}, 64'd0);
                busy_cnt = 0;
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("hi", {32'b0, hi}, {32'b0, e[63:32]});
                    check("lo", {32'b0, lo}, {32'b0, e[31:0]});
                    check("div_by_zero", {63'b0, div_by_zero}, {63'b0, e[64]});
                    cur_hi = e[63:32];
                    cur_lo = e[31:0];
                end
            end
        end
    end

    // Called at a negedge with the unit idle (or in its done cycle)
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit expect_done);
        op = o;
        operand_a = a;
        operand_b = b;
        start = 1'b1;
        if (expect_done) sb_q.push_back(ref_op(o, a, b));
        @(posedge clock);
        #1 start = 1'b0;
        @(negedge clock);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!done) check("done_timeout", 64'd1, 64'd0);
    endtask

    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        issue(o, a, b, 1'b1);
        wait_done();
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [1:0]  ro;
        reset = 1'b1; start = 1'b0; op = '0; operand_a = '0; operand_b = '0;
        mt_hi = 1'b0; mt_lo = 1'b0; mt_data = '0;
        repeat (2) @(negedge clock);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_dbz", {63'b0, div_by_zero}, 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        reset = 1'b0;
        @(negedge clock);

        // Multiply, including back-to-back starts in the done cycle
        do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(2'b01, 32'hFFFF_FFFD, 32'd7);
        do_op(2'b01, 32'h8000_0000, 32'd2);
        // Divide, signed corner and divide-by-zero
        do_op(2'b10, 32'd100, 32'd7);
        do_op(2'b11, 32'hFFFF_FFF9, 32'd2);
        do_op(2'b11, 32'd7, 32'hFFFF_FFFE);
        do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(2'b10, 32'd5, 32'd0);
        do_op(2'b11, 32'hFFFF_FFF0, 32'd0);
        do_op(2'b00, 32'd1, 32'd1);

        // Start pulse while busy is ignored
        @(negedge clock);
        issue(2'b00, 32'd3, 32'd4, 1'b1);
        repeat (4) @(negedge clock);
        op = 2'b00; operand_a = 32'd9; operand_b = 32'd9; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done();

        // Reset mid-operation: abort, clear HI/LO, no done
        @(negedge clock);
        issue(2'b01, 32'd5, 32'd6, 1'b0);
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("abort_busy", {63'b0, busy}, 64'd0);
        check("abort_done", {63'b0, done}, 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        cur_hi = '0; cur_lo = '0;
        reset = 1'b0;
        repeat (40) @(negedge clock);
        check("abort_no_done", {63'b0, done}, 64'd0);

        // MTHI / MTLO in idle
        mt_hi = 1'b1; mt_data = 32'h1234;
        @(posedge clock);
        #1 mt_hi = 1'b0;
        @(negedge clock);
        check("mthi_hi", {32'b0, hi}, 64'h1234);
        check("mthi_lo", {32'b0, lo}, 64'd0);
        cur_hi = 32'h1234;
        mt_hi = 1'b1; mt_lo = 1'b1; mt_data = 32'hA5A5_5A5A;
        @(posedge clock);
        #1 begin mt_hi = 1'b0; mt_lo = 1'b0; end
        @(negedge clock);
        check("mtboth", {hi, lo}, {32'hA5A5_5A5A, 32'hA5A5_5A5A});
        cur_hi = 32'hA5A5_5A5A; cur_lo = 32'hA5A5_5A5A;

        // mt_lo while busy is dropped (monitor checks lo stays put)
        issue(2'b00, 32'd2, 32'd3, 1'b1);
        mt_lo = 1'b1; mt_data = 32'hBEEF;
        repeat (3) @(negedge clock);
        mt_lo = 1'b0;
        wait_done();
        @(negedge clock);
        check("mt_busy_lo", {32'b0, lo}, 64'd6);

        // start with mt_lo in idle: start wins
        mt_lo = 1'b1; mt_data = 32'hDEAD;
        issue(2'b10, 32'd50, 32'd8, 1'b1);
        mt_lo = 1'b0;
        wait_done();

        // Randomized ops, mixing gaps and back-to-back starts
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 20));
                3: rb = 32'h8000_0000;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) ra = 32'h8000_0000;
            repeat ($urandom_range(0, 2)) @(negedge clock);
            do_op(ro, ra, rb);
        end

        repeat (3) @(negedge clock);
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative HI/LO multiply/divide unit for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Sits directly downstream of the register file: operand_a is fed from data_a and operand_b from data_b.
- Holds the HI/LO result registers, which the writeback path later reads for MFHI/MFLO.
- The control unit must hold its next MFHI/MFLO until done, using the busy/done handshake.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- ITER, 32, iteration count. Must equal WIDTH.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  launch an operation; sampled only in IDLE.
- op  in  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- operand_a  in  WIDTH  multiplicand or dividend, from data_a.
- operand_b  in  WIDTH  multiplier or divisor, from data_b.
- mt_hi  in  1  write mt_data into HI (MTHI).
- mt_lo  in  1  write mt_data into LO (MTLO).
- mt_data  in  WIDTH  MTHI/MTLO data.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- div_by_zero  out  1  last division had divisor 0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Clocking and reset:
  - One clock domain, named clock.
  - Reset is synchronous and active-high, named reset.
  - On reset: state=IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, iteration counter=0.
  - Reset mid-operation aborts the operation: no done pulse, HI/LO are cleared.
- FSM states: IDLE, CALC, FIX.
  - IDLE, start=1 at edge E0:
    - Latch op.
    - Latch |operand_a| and |operand_b|; absolute values apply only for signed ops.
    - Latch result signs, counter=0, go to CALC. busy=1 from the cycle after E0.
  - CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per edge.
    - Steps occur on edges E1..E32.
    - At counter==ITER-1, go to FIX.
  - FIX, at edge E33:
    - Apply sign correction and write hi/lo.
    - done=1 for exactly the cycle after E33; busy=0 in that cycle.
    - Return to IDLE.
  - busy is high for exactly 33 cycles.
  - A start asserted in the done cycle is accepted; there is no dead cycle.
- Arithmetic:
  - MULT/MULTU: {hi,lo} = full 64-bit product, signed two's complement for MULT.
  - DIV/DIVU: lo=quotient, hi=remainder.
  - Signed quotient truncates toward zero; remainder takes the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wraps, no flag).
  - Divisor 0 (DIV or DIVU):
    - Same 33-cycle latency.
    - Forced result hi=operand_a (raw), lo=0xFFFFFFFF.
    - div_by_zero=1, set with done.
  - div_by_zero is cleared on the next accepted start.
- Simultaneous events:
  - start while busy: ignored; operands are not re-latched.
  - mt_hi/mt_lo in IDLE: the selected register updates at the next edge.
  - mt_hi and mt_lo together: both update.
  - mt_* while busy: ignored.
  - start together with mt_* in IDLE: start wins and mt_* is dropped.
- Outputs:
  - hi/lo hold their values between operations.
  - HI/LO are unchanged during CALC; only FIX or mt_* modify them.

Decomposition:
- Shared package mdu_pkg:
  - op encodings OP_MULTU/OP_MULT/OP_DIVU/OP_DIV.
  - state typedef {IDLE, CALC, FIX}.
  - ITER constant.
  - Imported by the control unit for op generation.
- No sub-module: the shared 64-bit accumulator/shift datapath is tightly coupled to the FSM and stays in one module.

Test Plan:
1. MULTU 0xFFFFFFFF × 0xFFFFFFFF, start at E0 → busy 33 cycles; done the cycle after E33; hi=0xFFFFFFFE, lo=0x00000001.
2. MULT -3 × 7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. Back-to-back start in the done cycle, MULT 0x80000000 × 2 → hi=0xFFFFFFFF, lo=0x00000000.
3. DIVU 100/7 → lo=14, hi=2. DIV -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 7/-2 → lo=0xFFFFFFFD, hi=1.
4. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0, div_by_zero=0. DIVU 5/0 → lo=0xFFFFFFFF, hi=5, div_by_zero=1, cleared at next start.
5. Start MULTU 3×4, pulse start with 9×9 at cycle 5 → ignored; result hi=0, lo=12. Assert reset at cycle 10 of a new op → next cycle busy=0, hi=lo=0, no done pulse.
6. Idle mt_hi with mt_data=0x1234 → hi=0x1234 next cycle. mt_lo during busy → lo unchanged. start+mt_lo in IDLE → op runs, mt dropped.
